// File: rtl/ddr4_timing_monitor_if.sv
// Observed DDR4 command bus as seen by ddr4_timing_monitor.
// The controller (or the bench) drives it and the monitor only listens.
interface ddr4_timing_monitor_if #(
    parameter int NUM_BG = 4
) ();
    localparam int BG_W = $clog2(NUM_BG);

    logic            dram_reset_n;
    logic            cke;
    logic            cs_n;
    logic            act_n;
    logic            ras_n_a16;
    logic            cas_n_a15;
    logic            we_n_a14;
    logic [BG_W-1:0] bg;

    // Controller side: owns every signal on the bus.
    modport master (
        output dram_reset_n, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg
    );

    // Monitor side: passive observer.
    modport slave (
        input dram_reset_n, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, bg
    );
endinterface

// File: rtl/ddr4_timing_monitor.sv
// Passive DDR4 command-bus timing monitor.
// Checks CAS-to-CAS (tCCD_S/L), ACT-to-ACT (tRRD_S/L), the four-activate
// window (tFAW) and the CKE-after-reset delay (tCKE), and reports per-check
// pulses, a sticky error flag and a saturating violation count.

// Same/different bank-group spacing check for one command class.
// Ages read 1 on the cycle after a command, so the age seen by a new
// command is exactly its distance in cycles from the previous one.
module ddr4_timing_monitor_spacing #(
    parameter int NUM_BG = 4,
    parameter int T_L    = 6,
    parameter int T_S    = 4,
    parameter int BG_W   = $clog2(NUM_BG)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            cmd,
    input  logic [BG_W-1:0] bg,
    output logic            viol
);
    localparam int AGE_MAX = (T_L > T_S) ? T_L : T_S;
    localparam int AGE_W   = $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);
    localparam logic [AGE_W-1:0] LIM_L   = AGE_W'(T_L);
    localparam logic [AGE_W-1:0] LIM_S   = AGE_W'(T_S);

    logic [AGE_W-1:0]  age_bg [NUM_BG];
    logic [AGE_W-1:0]  age_all;
    logic [NUM_BG-1:0] seen_bg;
    logic [NUM_BG-1:0] bg_onehot;
    logic              same_close;
    logic              other_close;

    function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age);
        return (age < AGE_SAT) ? age + 1'b1 : age;
    endfunction

    // Same-group spacing takes precedence; the any-group check only applies
    // once some other bank group has issued this command class.
    // NOTE: every always_comb output is assigned unconditionally first, so no latch can be inferred.
    always_comb begin
        bg_onehot     = '0;
        bg_onehot[bg] = 1'b1;
        same_close    = seen_bg[bg] && (age_bg[bg] < LIM_L);
        other_close   = (|(seen_bg & ~bg_onehot)) && (age_all < LIM_S);
        viol          = cmd && (same_close || other_close);
    end

    // Global and per-group ages: restart at 1 after a command, then count up and saturate.
    // NOTE: non-blocking assignments make every flop take its pre-edge inputs, independent of statement order.
    // NOTE: the per-group ages are a few flops, not a RAM, so they are cleared by reset like all other state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            age_all <= '0;
            seen_bg <= '0;
            for (int i = 0; i < NUM_BG; i++) begin
                age_bg[i] <= '0;
            end
        end else begin
            age_all <= cmd ? AGE_W'(1) : age_step(age_all);
            if (cmd) begin
                seen_bg[bg] <= 1'b1;
            end
            for (int i = 0; i < NUM_BG; i++) begin
                age_bg[i] <= (cmd && (bg == BG_W'(i))) ? AGE_W'(1) : age_step(age_bg[i]);
            end
        end
    end
endmodule

module ddr4_timing_monitor #(
    parameter int NUM_BG  = 4,
    parameter int T_CCD_S = 4,
    parameter int T_CCD_L = 6,
    parameter int T_RRD_S = 4,
    parameter int T_RRD_L = 6,
    parameter int T_FAW   = 20,
    parameter int T_CKE   = 10,
    parameter int CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ddr4_timing_monitor_if.slave  bus,
    output logic                  viol_ccd,
    output logic                  viol_rrd,
    output logic                  viol_faw,
    output logic                  viol_cke,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      viol_count
);
    localparam int BG_W  = $clog2(NUM_BG);
    localparam int FAW_W = $clog2(T_FAW + 1);
    localparam int CKE_W = $clog2(T_CKE + 1);
    localparam logic [FAW_W-1:0] FAW_LIM = FAW_W'(T_FAW);
    localparam logic [CKE_W-1:0] CKE_LIM = CKE_W'(T_CKE);

    // CKE power-up tracker states.
    localparam logic [1:0] RST_HELD = 2'd0;
    localparam logic [1:0] WAIT     = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;

    // ------------------------------------------------------------------
    // Command decode: only meaningful while CKE is high and the rank is selected.
    // ------------------------------------------------------------------
    logic cmd_valid;
    logic is_act;
    logic is_rd;
    logic is_wr;
    logic is_cas;

    assign cmd_valid = bus.cke & ~bus.cs_n;
    assign is_act    = cmd_valid & ~bus.act_n;
    assign is_rd     = cmd_valid & bus.act_n & bus.ras_n_a16 & ~bus.cas_n_a15 & bus.we_n_a14;
    assign is_wr     = cmd_valid & bus.act_n & bus.ras_n_a16 & ~bus.cas_n_a15 & ~bus.we_n_a14;
    assign is_cas    = is_rd | is_wr;

    // ------------------------------------------------------------------
    // tCCD and tRRD share the same spacing rule, one instance per command class.
    // ------------------------------------------------------------------
    logic ccd_hit;
    logic rrd_hit;

    ddr4_timing_monitor_spacing #(
        .NUM_BG (NUM_BG),
        .T_L    (T_CCD_L),
        .T_S    (T_CCD_S),
        .BG_W   (BG_W)
    ) u_ccd (
        .clock   (clock),
        .reset_n (reset_n),
        .cmd     (is_cas),
        .bg      (bus.bg),
        .viol    (ccd_hit)
    );

    ddr4_timing_monitor_spacing #(
        .NUM_BG (NUM_BG),
        .T_L    (T_RRD_L),
        .T_S    (T_RRD_S),
        .BG_W   (BG_W)
    ) u_rrd (
        .clock   (clock),
        .reset_n (reset_n),
        .cmd     (is_act),
        .bg      (bus.bg),
        .viol    (rrd_hit)
    );

    // ------------------------------------------------------------------
    // tFAW: ages of the last four ACTs, entry 3 is the oldest.
    // ------------------------------------------------------------------
    logic [FAW_W-1:0] faw_age [4];
    logic [3:0]       faw_valid;
    logic             faw_hit;

    function automatic logic [FAW_W-1:0] faw_step(input logic [FAW_W-1:0] age);
        return (age < FAW_LIM) ? age + 1'b1 : age;
    endfunction

    // A fifth ACT is too early when the fourth-previous one is still inside the window.
    assign faw_hit = is_act && (&faw_valid) && (faw_age[3] < FAW_LIM);

    // Every ACT, violating or not, is shifted into the history.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            faw_valid <= '0;
            for (int i = 0; i < 4; i++) begin
                faw_age[i] <= '0;
            end
        end else if (is_act) begin
            faw_valid  <= {faw_valid[2:0], 1'b1};
            faw_age[0] <= FAW_W'(1);
            for (int i = 1; i < 4; i++) begin
                faw_age[i] <= faw_step(faw_age[i-1]);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                faw_age[i] <= faw_step(faw_age[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // tCKE: delay from DRAM reset release to the first CKE rise.
    // ------------------------------------------------------------------
    logic [1:0]       cke_state;
    logic [CKE_W-1:0] cke_cnt;
    logic             cke_q;
    logic             cke_rise;
    logic             cke_hit;

    assign cke_rise = bus.cke & ~cke_q;

    // Previous CKE is sampled on every edge, reset included, so a level that
    // was already high across a monitor reset is never mistaken for a rise.
    always_ff @(posedge clock) begin
        cke_q <= bus.cke;
    end

    // CKE must not rise while the DRAM is held in reset, nor too soon after release.
    always_comb begin
        cke_hit = 1'b0;
        if (!bus.dram_reset_n) begin
            cke_hit = cke_rise;
        end else if (cke_state == WAIT) begin
            cke_hit = cke_rise && (cke_cnt < CKE_LIM);
        end
    end

    // Power-up tracker: counts cycles since DRAM reset release until the first CKE rise.
    always_ff @(posedge clock) begin
        if (!reset_n || !bus.dram_reset_n) begin
            cke_state <= RST_HELD;
            cke_cnt   <= '0;
        end else begin
            case (cke_state)
                RST_HELD: begin
                    cke_state <= WAIT;
                    cke_cnt   <= CKE_W'(1);
                end
                WAIT: begin
                    if (cke_rise) begin
                        cke_state <= RUN;
                    end else if (cke_cnt < CKE_LIM) begin
                        cke_cnt <= cke_cnt + 1'b1;
                    end
                end
                RUN: begin
                    cke_state <= RUN;
                end
                default: begin
                    cke_state <= RST_HELD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reporting
    // ------------------------------------------------------------------
    logic [2:0]       hit_num;
    logic [CNT_W+2:0] count_sum;

    // Number of checks firing this cycle and the unsaturated running total.
    always_comb begin
        hit_num   = 3'(ccd_hit) + 3'(rrd_hit) + 3'(faw_hit) + 3'(cke_hit);
        count_sum = (CNT_W+3)'(viol_count) + (CNT_W+3)'(hit_num);
    end

    // Registered pulses, sticky flag and saturating counter all update on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            viol_ccd   <= 1'b0;
            viol_rrd   <= 1'b0;
            viol_faw   <= 1'b0;
            viol_cke   <= 1'b0;
            err_sticky <= 1'b0;
            viol_count <= '0;
        end else begin
            viol_ccd   <= ccd_hit;
            viol_rrd   <= rrd_hit;
            viol_faw   <= faw_hit;
            viol_cke   <= cke_hit;
            err_sticky <= err_sticky | (|hit_num);
            viol_count <= (|count_sum[CNT_W+2:CNT_W]) ? '1 : count_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_ddr4_timing_monitor.sv
// Self-checking bench for ddr4_timing_monitor: directed scenarios with
// hand-computed expectations, then randomized traffic, all compared every
// cycle against a time-stamp based reference model.
`timescale 1ns/1ps
module tb_ddr4_timing_monitor;
    localparam int NUM_BG  = 4;
    localparam int BG_W    = 2;
    localparam int T_CCD_S = 4;
    localparam int T_CCD_L = 6;
    localparam int T_RRD_S = 4;
    localparam int T_RRD_L = 6;
    localparam int T_FAW   = 20;
    localparam int T_CKE   = 10;

    typedef enum int {K_ACT, K_RD, K_WR, K_PRE, K_REF, K_DES} kind_t;
    typedef int last_t [NUM_BG];

    logic clock = 1'b0;
    logic reset_n;

    ddr4_timing_monitor_if #(.NUM_BG(NUM_BG)) bus ();

    logic        viol_ccd, viol_rrd, viol_faw, viol_cke, err_sticky;
    logic [15:0] viol_count;
    logic        c4_viol_ccd, c4_viol_rrd, c4_viol_faw, c4_viol_cke, c4_err_sticky;
    logic [3:0]  c4_viol_count;

    ddr4_timing_monitor #(
        .NUM_BG(NUM_BG), .T_CCD_S(T_CCD_S), .T_CCD_L(T_CCD_L), .T_RRD_S(T_RRD_S),
        .T_RRD_L(T_RRD_L), .T_FAW(T_FAW), .T_CKE(T_CKE), .CNT_W(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .viol_ccd(viol_ccd), .viol_rrd(viol_rrd), .viol_faw(viol_faw), .viol_cke(viol_cke),
        .err_sticky(err_sticky), .viol_count(viol_count)
    );

    ddr4_timing_monitor #(
        .NUM_BG(NUM_BG), .T_CCD_S(T_CCD_S), .T_CCD_L(T_CCD_L), .T_RRD_S(T_RRD_S),
        .T_RRD_L(T_RRD_L), .T_FAW(T_FAW), .T_CKE(T_CKE), .CNT_W(4)
    ) dut_c4 (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .viol_ccd(c4_viol_ccd), .viol_rrd(c4_viol_rrd), .viol_faw(c4_viol_faw), .viol_cke(c4_viol_cke),
        .err_sticky(c4_err_sticky), .viol_count(c4_viol_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remembers when each command happened and derives
    // every violation from cycle-number differences.
    // ------------------------------------------------------------------
    bit              model_live = 1'b0;
    bit [NUM_BG-1:0] cas_seen, act_seen;
    last_t           cas_last, act_last;
    int              act_hist[$];
    bit              cke_prev = 1'b0;
    bit              drst_hold = 1'b1;
    bit              cke_armed = 1'b0;
    int              drst_t0 = 0;
    bit              exp_ccd, exp_rrd, exp_faw, exp_cke, exp_err;
    int              exp_cnt, exp_cnt4;
    bit              e_ccd, e_rrd, e_faw, e_cke, m_rise, m_ok;
    int              m_bg, m_nv;

    function automatic bit spacing_viol(input bit [NUM_BG-1:0] seen, input last_t last,
                                        input int b, input int now, input int tl, input int ts);
        int newest = -1;
        bit other  = 1'b0;
        if (seen[b] && (now - last[b] < tl)) return 1'b1;
        for (int j = 0; j < NUM_BG; j++) begin
            if (seen[j]) begin
                if (j != b) other = 1'b1;
                if (last[j] > newest) newest = last[j];
            end
        end
        return other && (now - newest < ts);
    endfunction

    always @(posedge clock) begin
        e_ccd = 0; e_rrd = 0; e_faw = 0; e_cke = 0;
        if (!reset_n) begin
            cas_seen = '0; act_seen = '0; act_hist.delete();
            drst_hold = 1; cke_armed = 0;
            exp_ccd = 0; exp_rrd = 0; exp_faw = 0; exp_cke = 0; exp_err = 0;
            exp_cnt = 0; exp_cnt4 = 0;
            model_live = 1;
        end else begin
            m_ok = bus.cke && !bus.cs_n;
            m_bg = int'(bus.bg);
            if (m_ok && !bus.act_n) begin
                e_rrd = spacing_viol(act_seen, act_last, m_bg, cyc, T_RRD_L, T_RRD_S);
                if (act_hist.size() == 4 && (cyc - act_hist[0] < T_FAW)) e_faw = 1;
                act_hist.push_back(cyc);
                if (act_hist.size() > 4) void'(act_hist.pop_front());
                act_seen[m_bg] = 1; act_last[m_bg] = cyc;
            end else if (m_ok && bus.ras_n_a16 && !bus.cas_n_a15) begin
                e_ccd = spacing_viol(cas_seen, cas_last, m_bg, cyc, T_CCD_L, T_CCD_S);
                cas_seen[m_bg] = 1; cas_last[m_bg] = cyc;
            end
            m_rise = bus.cke && !cke_prev;
            if (!bus.dram_reset_n) begin
                if (m_rise) e_cke = 1;
                drst_hold = 1; cke_armed = 0;
            end else if (drst_hold) begin
                drst_hold = 0; cke_armed = 1; drst_t0 = cyc;
            end else if (cke_armed && m_rise) begin
                if (cyc - drst_t0 < T_CKE) e_cke = 1;
                cke_armed = 0;
            end
            exp_ccd = e_ccd; exp_rrd = e_rrd; exp_faw = e_faw; exp_cke = e_cke;
            m_nv = int'(e_ccd) + int'(e_rrd) + int'(e_faw) + int'(e_cke);
            exp_cnt  = (exp_cnt + m_nv > 65535) ? 65535 : exp_cnt + m_nv;
            exp_cnt4 = (exp_cnt4 + m_nv > 15) ? 15 : exp_cnt4 + m_nv;
            if (m_nv > 0) exp_err = 1;
        end
        cke_prev = bus.cke;
        cyc++;
    end

    // Compare both instances against the model shortly after every edge.
    always @(posedge clock) begin
        #2;
        if (model_live) begin
            check("viol_ccd", 32'(viol_ccd), 32'(exp_ccd));
            check("viol_rrd", 32'(viol_rrd), 32'(exp_rrd));
            check("viol_faw", 32'(viol_faw), 32'(exp_faw));
            check("viol_cke", 32'(viol_cke), 32'(exp_cke));
            check("err_sticky", 32'(err_sticky), 32'(exp_err));
            check("viol_count", 32'(viol_count), 32'(exp_cnt));
            check("c4_viols", 32'({c4_viol_ccd, c4_viol_rrd, c4_viol_faw, c4_viol_cke}),
                  32'({exp_ccd, exp_rrd, exp_faw, exp_cke}));
            check("c4_err_sticky", 32'(c4_err_sticky), 32'(exp_err));
            check("c4_viol_count", 32'(c4_viol_count), 32'(exp_cnt4));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge).
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic issue(input kind_t kind, input int b);
        bus.bg   = BG_W'(b);
        bus.cs_n = 1'b0;
        case (kind)
            K_ACT: begin
                bus.act_n = 1'b0;
                bus.ras_n_a16 = 1'($urandom); bus.cas_n_a15 = 1'($urandom); bus.we_n_a14 = 1'($urandom);
            end
            K_RD:  begin bus.act_n = 1; bus.ras_n_a16 = 1; bus.cas_n_a15 = 0; bus.we_n_a14 = 1; end
            K_WR:  begin bus.act_n = 1; bus.ras_n_a16 = 1; bus.cas_n_a15 = 0; bus.we_n_a14 = 0; end
            K_PRE: begin bus.act_n = 1; bus.ras_n_a16 = 0; bus.cas_n_a15 = 1; bus.we_n_a14 = 0; end
            K_REF: begin bus.act_n = 1; bus.ras_n_a16 = 0; bus.cas_n_a15 = 0; bus.we_n_a14 = 1; end
            default: begin bus.cs_n = 1; bus.act_n = 0; bus.ras_n_a16 = 1; bus.cas_n_a15 = 0; end
        endcase
        @(negedge clock);
        bus.cs_n = 1'b1; bus.act_n = 1'b1;
        bus.ras_n_a16 = 1'b1; bus.cas_n_a15 = 1'b1; bus.we_n_a14 = 1'b1;
    endtask

    task automatic power_up(input int delay);
        bus.dram_reset_n = 1'b0;
        bus.cke = 1'b0;
        idle($urandom_range(1, 4));
        if ($urandom_range(0, 2) == 0) begin
            bus.cke = 1'b1; idle(1);
            bus.cke = 1'b0; idle(1);
        end
        bus.dram_reset_n = 1'b1;
        idle(delay);
        bus.cke = 1'b1;
        idle(1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        bus.dram_reset_n = 1'b0; bus.cke = 1'b0; bus.cs_n = 1'b1; bus.act_n = 1'b1;
        bus.ras_n_a16 = 1'b1; bus.cas_n_a15 = 1'b1; bus.we_n_a14 = 1'b1; bus.bg = '0;
        idle(3);
        check("reset_count", 32'(viol_count), 32'd0);
        check("reset_err", 32'(err_sticky), 32'd0);
        check("reset_viols", 32'({viol_ccd, viol_rrd, viol_faw, viol_cke}), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // CKE 12 cycles after DRAM reset release: legal.
        bus.dram_reset_n = 1'b1; idle(1);
        idle(11);
        bus.cke = 1'b1; idle(1);
        check("cke_late_ok", 32'(viol_cke), 32'd0);
        check("cke_late_count", 32'(viol_count), 32'd0);

        // CKE 5 cycles after release: too early.
        bus.dram_reset_n = 1'b0; bus.cke = 1'b0; idle(3);
        bus.dram_reset_n = 1'b1; idle(1);
        idle(4);
        bus.cke = 1'b1; idle(1);
        check("cke_early_viol", 32'(viol_cke), 32'd1);
        check("cke_early_count", 32'(viol_count), 32'd1);
        check("cke_early_err", 32'(err_sticky), 32'd1);
        idle(1);
        check("cke_pulse_clear", 32'(viol_cke), 32'd0);

        // tCCD
        idle(8);
        issue(K_RD, 0); idle(3); issue(K_RD, 0);
        check("ccd_same_bg_d4", 32'(viol_ccd), 32'd1);
        idle(8);
        issue(K_RD, 0); idle(3); issue(K_RD, 1);
        check("ccd_diff_bg_d4", 32'(viol_ccd), 32'd0);
        idle(8);
        issue(K_RD, 0); idle(2); issue(K_RD, 1);
        check("ccd_diff_bg_d3", 32'(viol_ccd), 32'd1);

        // tRRD
        idle(8);
        issue(K_ACT, 0); idle(5); issue(K_ACT, 0);
        check("rrd_same_bg_d6", 32'(viol_rrd), 32'd0);
        idle(8);
        issue(K_ACT, 1); idle(1); issue(K_ACT, 2);
        check("rrd_diff_bg_d2", 32'(viol_rrd), 32'd1);
        check("rrd_no_faw", 32'(viol_faw), 32'd0);

        // tFAW: fifth ACT at 16 then at 20
        idle(25);
        issue(K_ACT, 0); idle(3); issue(K_ACT, 1); idle(3); issue(K_ACT, 2); idle(3); issue(K_ACT, 3);
        check("faw_4th_ok", 32'(viol_faw), 32'd0);
        idle(3); issue(K_ACT, 0);
        check("faw_5th_at16", 32'(viol_faw), 32'd1);
        check("faw_5th_no_rrd", 32'(viol_rrd), 32'd0);
        idle(25);
        issue(K_ACT, 0); idle(3); issue(K_ACT, 1); idle(3); issue(K_ACT, 2); idle(3); issue(K_ACT, 3);
        idle(7); issue(K_ACT, 0);
        check("faw_5th_at20", 32'(viol_faw), 32'd0);
        check("count_after_directed", 32'(viol_count), 32'd5);

        // Reset discards history
        idle(8);
        issue(K_ACT, 0); idle(1); issue(K_ACT, 0);
        check("rrd_before_reset", 32'(viol_rrd), 32'd1);
        reset_n = 1'b0; idle(1);
        reset_n = 1'b1;
        issue(K_ACT, 1);
        check("post_reset_rrd", 32'(viol_rrd), 32'd0);
        check("post_reset_count", 32'(viol_count), 32'd0);
        check("post_reset_err", 32'(err_sticky), 32'd0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 22; i++) begin
            issue(K_ACT, 0); idle(1);
        end
        check("c4_saturated", 32'(c4_viol_count), 32'd15);
        check("c4_err_held", 32'(c4_err_sticky), 32'd1);

        // Randomized traffic
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            if ($urandom_range(0, 5) == 0) power_up($urandom_range(1, 14));
            if ($urandom_range(0, 7) == 0) begin
                reset_n = 1'b0; idle($urandom_range(1, 2)); reset_n = 1'b1;
            end
            len = $urandom_range(30, 80);
            for (int k = 0; k < len; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 35)      issue(K_ACT, $urandom_range(0, NUM_BG-1));
                else if (r < 55) issue(K_RD, $urandom_range(0, NUM_BG-1));
                else if (r < 70) issue(K_WR, $urandom_range(0, NUM_BG-1));
                else if (r < 76) issue(K_PRE, $urandom_range(0, NUM_BG-1));
                else if (r < 80) issue(K_REF, $urandom_range(0, NUM_BG-1));
                else if (r < 85) issue(K_DES, $urandom_range(0, NUM_BG-1));
                else if (r < 90) begin
                    bus.cke = 1'b0; idle(1); bus.cke = 1'b1;
                end
                idle($urandom_range(0, 5));
            end
        end

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr4_timing_monitor.md
Name: ddr4_timing_monitor

Overview:
- Synthesizable, parametrised successor to the DDR4 assertion checker library; passively snoops the controller-to-DIMM command bus.
- Checks four timings in hardware: tCKE after DRAM reset, tCCD_S/L (CAS to CAS), tRRD_S/L (ACT to ACT), and tFAW.
- tFAW was not checked before and is checked here. Bank-group count and all timings are parameters.
- Reports per-check violation pulses, a sticky error flag and a saturating violation counter to the testbench scoreboard.

Parameters:
- NUM_BG, 4, number of bank groups (power of 2, >=2); BG_W = $clog2(NUM_BG)
- T_CCD_S, 4, min cycles CAS to CAS, different bank group
- T_CCD_L, 6, min cycles CAS to CAS, same bank group
- T_RRD_S, 4, min cycles ACT to ACT, different bank group
- T_RRD_L, 6, min cycles ACT to ACT, same bank group
- T_FAW, 20, window within which at most 4 ACTs are permitted
- T_CKE, 10, min cycles from dram_reset_n rise to cke rise
- CNT_W, 16, width of violation counter

Ports:
- clock  in  1  monitor clock (same as DDR4 CK_t)
- reset_n  in  1  synchronous active-low monitor reset
- dram_reset_n  in  1  observed DRAM RESET_n
- cke  in  1  observed CKE
- cs_n  in  1  observed chip select
- act_n  in  1  observed ACT_n
- ras_n_a16  in  1  observed RAS_n/A16
- cas_n_a15  in  1  observed CAS_n/A15
- we_n_a14  in  1  observed WE_n/A14
- bg  in  BG_W  observed bank group
- viol_ccd  out  1  one-cycle pulse, tCCD violation
- viol_rrd  out  1  one-cycle pulse, tRRD violation
- viol_faw  out  1  one-cycle pulse, tFAW violation
- viol_cke  out  1  one-cycle pulse, tCKE/CKE-during-reset violation
- err_sticky  out  1  set on any violation, cleared only by reset_n
- viol_count  out  CNT_W  total violations, saturating at all-ones

Behaviour:
- Reset: reset_n low at a clock edge clears all outputs to 0, all age counters, all "seen" flags and the FAW history. The CKE FSM goes to RST_HELD. Reset mid-sequence discards all history; the first command after reset never violates.
- Decode is combinational and sampled only when cke=1 and cs_n=0.
  - ACT = act_n=0.
  - CAS = act_n=1, ras_n_a16=1, cas_n_a15=0. Both RD (we=1) and WR (we=0) count as CAS.
  - All other commands are ignored.
- Age counters: one global plus one per BG, for each of CAS and ACT.
  - A counter loads 1 on the cycle after its command and increments each cycle.
  - It saturates at max(T_*_L, T_*_S).
  - Distance to a new command = current age. Back-to-back commands give distance 1.
- tCCD: on CAS to bg b:
  - if a prior CAS to b exists and age_b < T_CCD_L, violate;
  - else if a prior CAS to any other BG exists and global age < T_CCD_S, violate.
  - At most one viol_ccd per command.
- tRRD: identical rule for ACT using T_RRD_L/T_RRD_S.
- tFAW:
  - Keep ages of the last 4 ACTs in a 4-entry shift history with valid bits. Ages saturate at T_FAW.
  - On ACT: if all 4 entries are valid and the oldest age < T_FAW, violate. In either case, shift the new ACT in and drop the oldest.
  - A violating ACT is still recorded in every history.
- CKE FSM:
  - RST_HELD: dram_reset_n=0. A cke 0->1 edge here sets viol_cke. On dram_reset_n=1, go to WAIT and set the counter to 1.
  - WAIT: counter increments, saturating at T_CKE. On a cke 0->1 edge: set viol_cke if counter < T_CKE, then go to RUN.
  - RUN: no checking.
  - From any state, dram_reset_n=0 returns the FSM to RST_HELD.
- Latency: all viol_* outputs are registered and assert exactly 1 cycle after the offending command or edge is sampled.
- viol_count increments by the number of viol_* asserted that cycle (0..4) and saturates.
- err_sticky asserts in the same cycle as the first viol_*.

Test Plan:
- reset_n low, dram_reset_n 0->1, cke rises 12 cycles later -> no viol_cke; repeat with cke rising after 5 cycles -> viol_cke=1 one cycle after the edge, viol_count=1, err_sticky=1.
- RD bg0, RD bg0 4 cycles later -> viol_ccd (needs 6); RD bg0, RD bg1 4 cycles later -> none; RD bg0, RD bg1 3 cycles later -> viol_ccd.
- ACT bg0, ACT bg0 6 cycles later -> none; ACT bg1 then ACT bg2 2 cycles later -> viol_rrd.
- ACTs to bg0,1,2,3,0 every 4 cycles (5th ACT at 16 < 20) -> viol_faw only on the 5th ACT; same sequence with the 5th ACT at 20 -> no viol_faw.
- Violating ACT at cycle 2 after a prior ACT, then reset_n low for 1 cycle, then immediate ACT -> no violation after reset; viol_count=0, err_sticky=0.
- Force 2^CNT_W+3 violations with CNT_W=4 override -> viol_count holds at 15, err_sticky stays 1.
